// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial adder: captures {A, B, cin}
// and streams them LSB-first with framing flags. Define SERIAL_FEEDER_SKID_EN for a one-word skid buffer.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             a,
  output logic             b,
  output logic             cin,
  output logic             bit_valid,
  output logic             first,
  output logic             last,
  output logic             adder_clr,
  output logic             word_done,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends on registered state only, never on in_valid.
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] sh_a_q, sh_b_q;
  logic             a_q, b_q, cin_q, first_q, last_q, bit_valid_q, adder_clr_q, word_done_q;

  logic             accept;
  logic             ld_en;
  logic [WIDTH-1:0] ld_a, ld_b;
  logic             ld_cin;

  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef SERIAL_FEEDER_SKID_EN
  logic             buf_full_q;
  logic [WIDTH-1:0] buf_a_q, buf_b_q;
  logic             buf_cin_q;
  logic             ld_from_buf;
  logic             buf_wr;

  assign in_ready = !buf_full_q;

  // A buffered word always wins the load slot; a fresh word then takes its place.
  always_comb begin
    ld_from_buf = buf_full_q && (state_q != SHIFT);
    ld_en       = ld_from_buf || (accept && (state_q != SHIFT));
    ld_a        = ld_from_buf ? buf_a_q   : in_a;
    ld_b        = ld_from_buf ? buf_b_q   : in_b;
    ld_cin      = ld_from_buf ? buf_cin_q : in_cin;
    buf_wr      = accept && ((state_q == SHIFT) || ld_from_buf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full_q <= 1'b0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      buf_cin_q  <= 1'b0;
    end else if (buf_wr) begin
      buf_full_q <= 1'b1;
      buf_a_q    <= in_a;
      buf_b_q    <= in_b;
      buf_cin_q  <= in_cin;
    end else if (ld_from_buf) begin
      buf_full_q <= 1'b0;
    end
  end
`else
  assign in_ready = (state_q == IDLE);

  always_comb begin
    ld_en  = accept && (state_q != SHIFT);
    ld_a   = in_a;
    ld_b   = in_b;
    ld_cin = in_cin;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      cin_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      adder_clr_q <= 1'b1;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (ld_en) begin
            // Bit 0 goes straight to the outputs; the remainder waits in the shifters.
            state_q     <= SHIFT;
            cnt_q       <= '0;
            sh_a_q      <= ld_a >> 1;
            sh_b_q      <= ld_b >> 1;
            a_q         <= ld_a[0];
            b_q         <= ld_b[0];
            cin_q       <= ld_cin;
            first_q     <= 1'b1;
            last_q      <= (LAST_BIT == '0);
            bit_valid_q <= 1'b1;
            adder_clr_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            state_q     <= GAP;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cin_q       <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            adder_clr_q <= 1'b1;
            word_done_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_inc;
            a_q     <= sh_a_q[0];
            b_q     <= sh_b_q[0];
            sh_a_q  <= sh_a_q >> 1;
            sh_b_q  <= sh_b_q >> 1;
            cin_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= (cnt_inc == LAST_BIT);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign cin       = cin_q;
  assign first     = first_q;
  assign last      = last_q;
  assign bit_valid = bit_valid_q;
  assign adder_clr = adder_clr_q;
  assign word_done = word_done_q;
  assign state_dbg = state_q;

endmodule
